// File: rtl/alu_pipelined_multdiv.sv
// Execute-stage ALU: single-cycle add/sub/logic/shift ops plus iterative signed multiply and
// divide, with every result registered behind a start/ready handshake.
module alu_pipelined_multdiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_start,
  input  logic [4:0]       ctrl_ALUopcode,
  input  logic [SHW-1:0]   ctrl_shiftamt,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic             ctrl_busy,
  output logic             data_resultRDY,
  output logic [WIDTH-1:0] data_result,
  output logic             isNotEqual,
  output logic             isLessThan,
  output logic             overflow,
  output logic             data_exception
);

  localparam int unsigned     CW     = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StIter, StFin} state_e;

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_is_div, r_neg, r_ne, r_lt, r_bzero, r_minneg1;
  logic [WIDTH-1:0] r_b, r_hi, r_lo;
  logic             r_busy, r_rdy, r_ne_o, r_lt_o, r_ovf, r_exc;
  logic [WIDTH-1:0] r_result;

  logic             w_accept, w_muldiv, w_valid, w_ovf, w_ne, w_lt;
  logic [WIDTH-1:0] w_res, w_sum, w_diff, w_mag_a, w_mag_b;
  logic             w_sign_a, w_sign_b;

  assign w_sign_a = data_operandA[WIDTH-1];
  assign w_sign_b = data_operandB[WIDTH-1];
  assign w_accept = ctrl_start && !r_busy;
  assign w_muldiv = (ctrl_ALUopcode == 5'b00110) || (ctrl_ALUopcode == 5'b00111);
  assign w_ne     = data_operandA != data_operandB;
  assign w_lt     = $signed(data_operandA) < $signed(data_operandB);
  assign w_sum    = data_operandA + data_operandB;
  assign w_diff   = data_operandA + ~data_operandB + {{(WIDTH-1){1'b0}}, 1'b1};
  // MIN maps onto 2^(WIDTH-1), which still fits as an unsigned magnitude.
  assign w_mag_a  = w_sign_a ? -data_operandA : data_operandA;
  assign w_mag_b  = w_sign_b ? -data_operandB : data_operandB;

  always_comb begin
    w_res   = '0;
    w_ovf   = 1'b0;
    w_valid = 1'b1;
    case (ctrl_ALUopcode)
      5'b00000: begin
        w_res = w_sum;
        w_ovf = (w_sign_a == w_sign_b) && (w_sum[WIDTH-1] != w_sign_a);
      end
      5'b00001: begin
        w_res = w_diff;
        w_ovf = (w_sign_a != w_sign_b) && (w_diff[WIDTH-1] != w_sign_a);
      end
      5'b00010: w_res = data_operandA & data_operandB;
      5'b00011: w_res = data_operandA | data_operandB;
      5'b00100: w_res = data_operandA << ctrl_shiftamt;
      5'b00101: w_res = $signed(data_operandA) >>> ctrl_shiftamt;
      5'b00110, 5'b00111: w_res = '0;
      default:  w_valid = 1'b0;
    endcase
  end

  // Multiply: shift-add with {r_hi, r_lo} as the product, r_lo doubling as the multiplier.
  // Divide: restoring with r_hi as remainder, r_lo shifting dividend out and quotient in.
  logic [WIDTH:0]     w_add, w_shift;
  logic [WIDTH-1:0]   w_sub, w_quot;
  logic               w_ge, w_mul_ovf;
  logic [2*WIDTH-1:0] w_prod, w_sprod;
  logic [WIDTH:0]     w_top;

  assign w_add     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
  assign w_shift   = {r_hi, r_lo[WIDTH-1]};
  assign w_ge      = w_shift >= {1'b0, r_b};
  assign w_sub     = w_shift[WIDTH-1:0] - r_b;
  assign w_prod    = {r_hi, r_lo};
  assign w_sprod   = r_neg ? -w_prod : w_prod;
  assign w_top     = w_sprod[2*WIDTH-1:WIDTH-1];
  assign w_mul_ovf = !((&w_top) || !(|w_top));
  assign w_quot    = r_neg ? -r_lo : r_lo;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg     <= 1'b0;
      r_ne      <= 1'b0;
      r_lt      <= 1'b0;
      r_bzero   <= 1'b0;
      r_minneg1 <= 1'b0;
      r_b       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_rdy     <= 1'b0;
      r_result  <= '0;
      r_ne_o    <= 1'b0;
      r_lt_o    <= 1'b0;
      r_ovf     <= 1'b0;
      r_exc     <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_accept && w_muldiv) begin
            r_state   <= StIter;
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_is_div  <= ctrl_ALUopcode[0];
            r_neg     <= w_sign_a ^ w_sign_b;
            r_hi      <= '0;
            r_lo      <= w_mag_a;
            r_b       <= w_mag_b;
            r_ne      <= w_ne;
            r_lt      <= w_lt;
            r_bzero   <= data_operandB == '0;
            r_minneg1 <= (data_operandA == MinVal) && (data_operandB == '1);
          end else if (w_accept) begin
            r_rdy    <= 1'b1;
            r_result <= w_res;
            r_ne_o   <= w_valid && w_ne;
            r_lt_o   <= w_valid && w_lt;
            r_ovf    <= w_ovf;
            r_exc    <= 1'b0;
          end
        end
        StIter: begin
          if (r_cnt == CW'(WIDTH)) begin
            r_state <= StFin;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_is_div) begin
              r_hi <= w_ge ? w_sub : w_shift[WIDTH-1:0];
              r_lo <= {r_lo[WIDTH-2:0], w_ge};
            end else begin
              r_hi <= w_add[WIDTH:1];
              r_lo <= {w_add[0], r_lo[WIDTH-1:1]};
            end
          end
        end
        StFin: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_rdy   <= 1'b1;
          r_ne_o  <= r_ne;
          r_lt_o  <= r_lt;
          if (!r_is_div) begin
            r_result <= w_sprod[WIDTH-1:0];
            r_ovf    <= w_mul_ovf;
            r_exc    <= w_mul_ovf;
          end else if (r_bzero) begin
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_exc    <= 1'b1;
          end else if (r_minneg1) begin
            r_result <= MinVal;
            r_ovf    <= 1'b1;
            r_exc    <= 1'b1;
          end else begin
            r_result <= w_quot;
            r_ovf    <= 1'b0;
            r_exc    <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign ctrl_busy      = r_busy;
  assign data_resultRDY = r_rdy;
  assign data_result    = r_result;
  assign isNotEqual     = r_ne_o;
  assign isLessThan     = r_lt_o;
  assign overflow       = r_ovf;
  assign data_exception = r_exc;

endmodule

// File: tb/tb_alu_pipelined_multdiv.sv
// Randomised and directed checks of alu_pipelined_multdiv against an arithmetic reference model.
module tb_alu_pipelined_multdiv;

  typedef struct packed {
    logic [63:0] res;
    logic        ne, lt, ovf, exc, cmp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  op, sh;
  logic [31:0] a, b;
  logic        busy, rdy, ne, lt, ovf, exc;
  logic [31:0] res;

  logic        s8;
  logic [4:0]  op8;
  logic [2:0]  sh8;
  logic [7:0]  a8, b8, res8;
  logic        busy8, rdy8, ne8, lt8, ovf8, exc8;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  exp_t exp_at[int];
  int   m_bfirst = 1, m_blast = 0, m_last_due = 0;
  exp_t m_last = '0;

  always #5 clk = ~clk;

  alu_pipelined_multdiv #(.WIDTH(32)) dut32 (
    .clock(clk), .reset_n(rst_n), .ctrl_start(start), .ctrl_ALUopcode(op), .ctrl_shiftamt(sh),
    .data_operandA(a), .data_operandB(b), .ctrl_busy(busy), .data_resultRDY(rdy),
    .data_result(res), .isNotEqual(ne), .isLessThan(lt), .overflow(ovf), .data_exception(exc)
  );

  alu_pipelined_multdiv #(.WIDTH(8)) dut8 (
    .clock(clk), .reset_n(rst_n), .ctrl_start(s8), .ctrl_ALUopcode(op8), .ctrl_shiftamt(sh8),
    .data_operandA(a8), .data_operandB(b8), .ctrl_busy(busy8), .data_resultRDY(rdy8),
    .data_result(res8), .isNotEqual(ne8), .isLessThan(lt8), .overflow(ovf8),
    .data_exception(exc8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic longint sx(input logic [63:0] v, input int w);
    logic [63:0] t;
    t = v << (64 - w);
    return $signed(t) >>> (64 - w);
  endfunction

  // Reference: true signed arithmetic on sign-extended operands, then truncate.
  function automatic exp_t model_op(input int w, input logic [4:0] o, input logic [63:0] ar,
                                    input logic [63:0] br, input int s);
    exp_t        e;
    longint      x, y, t, mx, mn;
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    x = sx(ar, w);
    y = sx(br, w);
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -mx - 1;
    e = '0;
    e.cmp = 1'b1;
    e.ne = x != y;
    e.lt = x < y;
    case (o)
      5'd0: begin t = x + y; e.res = 64'(t) & mask; e.ovf = (t > mx) || (t < mn); end
      5'd1: begin t = x - y; e.res = 64'(t) & mask; e.ovf = (t > mx) || (t < mn); end
      5'd2: e.res = ar & br & mask;
      5'd3: e.res = (ar | br) & mask;
      5'd4: e.res = (ar << s) & mask;
      5'd5: begin t = x >>> s; e.res = 64'(t) & mask; end
      5'd6: begin
        t = x * y;
        e.res = 64'(t) & mask;
        e.ovf = (t > mx) || (t < mn);
        e.exc = e.ovf;
      end
      5'd7: begin
        if (y == 0) begin
          e.exc = 1'b1;
        end else if (x == mn && y == -1) begin
          e.res = 64'(mn) & mask;
          e.ovf = 1'b1;
          e.exc = 1'b1;
        end else begin
          t = x / y;
          e.res = 64'(t) & mask;
        end
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  // Model of the 32-bit unit: accept when idle, schedule the expected result.
  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    bit   md;
    int   due;
    if (!rst_n) begin
      exp_at.delete();
      m_bfirst = 1;
      m_blast = 0;
      m_last_due = 0;
    end else begin
      cyc = cyc + 1;
      if (start && !((cyc - 1) >= m_bfirst && (cyc - 1) <= m_blast)) begin
        e = model_op(32, op, {32'b0, a}, {32'b0, b}, int'(sh));
        md = (op == 5'd6) || (op == 5'd7);
        due = cyc + (md ? 34 : 0);
        exp_at[due] = e;
        m_last_due = due;
        if (md) begin
          m_bfirst = cyc;
          m_blast = cyc + 33;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    bit   er, eb;
    if (!rst_n) m_last = '0;
    er = rst_n && exp_at.exists(cyc);
    eb = rst_n && cyc >= m_bfirst && cyc <= m_blast;
    chk("rdy", rdy, er);
    chk("busy", busy, eb);
    if (er) begin
      e = exp_at[cyc];
      m_last = e;
      chk("ovf", ovf, e.ovf);
      chk("exc", exc, e.exc);
      if (e.cmp) begin
        chk("ne", ne, e.ne);
        chk("lt", lt, e.lt);
      end
    end
    chk("result", res, m_last.res);
  end

  task automatic run32(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit spam, output logic [31:0] r, output logic v,
                       output logic xo, output int lat);
    @(negedge clk);
    op = o; a = x; b = y; sh = 5'd0; start = 1'b1;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (rdy) begin
        lat = i - 1;
        break;
      end
      if (spam) begin
        chk("busy_held", busy, 1);
        a = $urandom;
        b = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    if (!spam) start = 1'b0;
    r = res; v = ovf; xo = exc;
  endtask

  task automatic run8(input logic [4:0] o, input logic [7:0] x, input logic [7:0] y,
                      input logic [2:0] s);
    exp_t e;
    int   lat;
    e = model_op(8, o, {56'b0, x}, {56'b0, y}, int'(s));
    @(negedge clk);
    op8 = o; a8 = x; b8 = y; sh8 = s; s8 = 1'b1;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      s8 = 1'b0;
      if (rdy8) begin
        lat = i - 1;
        break;
      end
      chk("w8_busy", busy8, 1);
    end
    chk("w8_lat", lat, (o == 5'd6 || o == 5'd7) ? 10 : 0);
    chk("w8_res", res8, e.res);
    chk("w8_ovf", ovf8, e.ovf);
    chk("w8_exc", exc8, e.exc);
    if (e.cmp) begin
      chk("w8_ne", ne8, e.ne);
      chk("w8_lt", lt8, e.lt);
    end
  endtask

  function automatic logic [31:0] rv();
    case ($urandom % 8)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom % 16);
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    exp_t        e;
    logic [31:0] r;
    logic        v, xo;
    int          lat, cnt;

    rst_n = 1'b0; start = 1'b0; op = '0; sh = '0; a = '0; b = '0;
    s8 = 1'b0; op8 = '0; sh8 = '0; a8 = '0; b8 = '0;
    #2;
    chk("reset_outputs", {busy, rdy, res, ne, lt, ovf, exc}, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    e = model_op(32, 5'd0, 64'h7FFF_FFFF, 64'h1, 0);
    chk("pin_add_res", e.res, 64'h8000_0000);
    chk("pin_add_ovf", e.ovf, 1);
    e = model_op(32, 5'd7, 64'h8000_0000, 64'hFFFF_FFFF, 0);
    chk("pin_div_min", {e.res, e.ovf, e.exc}, {64'h8000_0000, 2'b11});
    e = model_op(8, 5'd6, 64'd12, 64'hF5, 0);
    chk("pin_mul8", {e.res, e.ovf}, {64'h7C, 1'b1});

    // Back-to-back single-cycle ops.
    @(negedge clk);
    op = 5'd0; a = 32'h7FFF_FFFF; b = 32'd1; start = 1'b1;
    @(negedge clk);
    chk("b2b_add_rdy", rdy, 1);
    chk("b2b_add_res", res, 32'h8000_0000);
    chk("b2b_add_ovf", ovf, 1);
    op = 5'd1; a = 32'd5; b = 32'd9;
    @(negedge clk);
    chk("b2b_sub_rdy", rdy, 1);
    chk("b2b_sub_res", res, 32'hFFFF_FFFC);
    chk("b2b_sub_flags", {ovf, lt, ne}, 3'b011);
    op = 5'd5; a = 32'h8000_0000; b = 32'd0; sh = 5'd4;
    @(negedge clk);
    chk("b2b_sra_rdy", rdy, 1);
    chk("b2b_sra_res", res, 32'hF800_0000);
    start = 1'b0;

    run32(5'd6, -32'sd3, 32'd7, 1'b0, r, v, xo, lat);
    chk("mul_neg_res", r, 32'hFFFF_FFEB);
    chk("mul_neg_exc", xo, 0);
    chk("mul_latency", lat, 34);
    run32(5'd6, 32'h0001_0000, 32'h0001_0000, 1'b0, r, v, xo, lat);
    chk("mul_ovf", {r, v, xo}, {32'h0, 2'b11});
    run32(5'd7, -32'sd17, 32'd5, 1'b0, r, v, xo, lat);
    chk("div_neg_res", r, 32'hFFFF_FFFD);
    chk("div_latency", lat, 34);
    run32(5'd7, 32'd17, 32'd0, 1'b0, r, v, xo, lat);
    chk("div_zero", {r, v, xo}, {32'h0, 2'b01});
    chk("div_zero_latency", lat, 34);
    run32(5'd7, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, r, v, xo, lat);
    chk("div_min_m1", {r, v, xo}, {32'h8000_0000, 2'b11});

    // Start held high with fresh operands throughout a divide.
    run32(5'd7, 32'd1000, -32'sd7, 1'b1, r, v, xo, lat);
    chk("busy_div_res", r, 32'hFFFF_FF72);
    chk("busy_div_latency", lat, 34);
    op = 5'd0; a = 32'd100; b = 32'd23;
    @(negedge clk);
    chk("after_busy_rdy", rdy, 1);
    chk("after_busy_res", res, 32'd123);
    start = 1'b0;

    // Reset in the middle of a multiply.
    @(negedge clk);
    op = 5'd6; a = 32'd7; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midop_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midop_reset_outputs", {busy, rdy, res, ne, lt, ovf, exc}, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    cnt = 0;
    repeat (45) begin
      @(negedge clk);
      if (rdy) cnt++;
    end
    chk("midop_no_rdy", cnt, 0);
    chk("midop_idle", busy, 0);

    // Randomised traffic, checked every cycle against the model.
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      start = ($urandom % 3) != 0;
      op = 5'($urandom_range(0, 9));
      if (op >= 5'd8) op = 5'($urandom_range(8, 31));
      a = rv();
      b = rv();
      sh = 5'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("drain_pending", m_last_due > cyc, 0);

    run8(5'd6, 8'd12, 8'hF5, 3'd0);
    chk("w8_mul_res", res8, 8'h7C);
    chk("w8_mul_ovf", ovf8, 1);
    run8(5'd4, 8'h01, 8'h00, 3'd7);
    chk("w8_sll_res", res8, 8'h80);
    run8(5'd7, 8'h80, 8'hFF, 3'd0);
    for (int i = 0; i < 20; i++) begin
      run8(5'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 3'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
